// File: rtl/ids_pkt_pkg.sv
// Shared definitions for the ids_pkt_gen test-packet generator.
package ids_pkt_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      MOD_HDR = 3'd1,
      HDR     = 3'd2,
      PAYLOAD = 3'd3,
      GAP     = 3'd4
   } state_e;

   localparam logic [7:0] CTRL_MOD_HDR = 8'hFF;
   localparam logic [7:0] CTRL_BODY    = 8'h00;
   localparam logic [7:0] CTRL_LAST    = 8'h01;

   localparam logic [63:0] HDR_W1 = 64'h4944_5348_4452_0001;
   localparam logic [63:0] HDR_W2 = 64'h4944_5348_4452_0002;
   localparam logic [63:0] HDR_W3 = 64'h4944_5348_4452_0003;

   localparam int NUM_HDR_WORDS = 3;

   // Fixed header word selected by its index within the HDR phase.
   function automatic logic [63:0] hdr_word(input logic [1:0] idx);
      case (idx)
         2'd0:    return HDR_W1;
         2'd1:    return HDR_W2;
         default: return HDR_W3;
      endcase
   endfunction

endpackage

// File: rtl/ids_pkt_gen.sv
// ids_pkt_gen: runs of synthetic packets (module header, 3 fixed header
// words, payload with optional pattern word) toward a 64-bit data path.
//
// state   | meaning
// IDLE    | waiting for start; configuration latched on start
// MOD_HDR | emit module header word (ctrl FF)
// HDR     | emit the three fixed header words (ctrl 00)
// PAYLOAD | emit payload words; final word tagged ctrl 01
// GAP     | inter-packet idle, gap counter counts down to 1
module ids_pkt_gen
   import ids_pkt_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int CTRL_WIDTH = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [CTRL_WIDTH-1:0] out_ctrl,
   output logic                  out_wr,
   input  logic                  out_rdy,
   input  logic                  start,
   input  logic                  stop,
   input  logic [31:0]           num_pkts,
   input  logic [7:0]            payload_len,
   input  logic [7:0]            gap_cycles,
   input  logic [7:0]            dst_port,
   input  logic [63:0]           pattern,
   input  logic                  pat_en,
   input  logic [7:0]            pat_offset,
   input  logic                  clear_cnt,
   output logic                  busy,
   output logic [31:0]           pkts_sent
);

   localparam logic [7:0] LAST_HDR_IDX = 8'(NUM_HDR_WORDS - 1);

   state_e                  state_q, state_d;
   logic                    out_wr_q, out_wr_d;
   logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
   logic [CTRL_WIDTH-1:0]   out_ctrl_q, out_ctrl_d;
   logic                    busy_q, busy_d;
   logic [31:0]             pkts_sent_q, pkts_sent_d;
   logic                    stop_pend_q, stop_pend_d;
   logic [7:0]              word_cnt_q, word_cnt_d;
   logic [7:0]              gap_cnt_q, gap_cnt_d;
   logic [31:0]             pkt_idx_q, pkt_idx_d;

   logic [31:0]             num_pkts_q, num_pkts_d;
   logic [7:0]              plen_q, plen_d;
   logic [7:0]              gap_q, gap_d;
   logic [7:0]              dst_q, dst_d;
   logic [63:0]             pattern_q, pattern_d;
   logic                    pat_en_q, pat_en_d;
   logic [7:0]              pat_off_q, pat_off_d;

   logic [15:0]             word_len;
   logic [15:0]             byte_len;
   logic                    last_pay;
   logic                    pat_hit;
   logic [31:0]             pkt_idx_inc;
   logic                    quota_next;
   logic                    quota_now;
   logic                    stop_req;

   assign word_len    = {8'h00, plen_q} + 16'd3;
   assign byte_len    = word_len << 3;
   assign last_pay    = (word_cnt_q == plen_q - 8'd1);
   assign pat_hit     = pat_en_q && (word_cnt_q == pat_off_q);
   assign pkt_idx_inc = pkt_idx_q + 32'd1;
   assign quota_next  = (num_pkts_q != 32'd0) && (pkt_idx_inc == num_pkts_q);
   assign quota_now   = (num_pkts_q != 32'd0) && (pkt_idx_q == num_pkts_q);
   assign stop_req    = stop_pend_q || stop;

   // Next-state, word generation and counter updates.
   always_comb begin
      state_d     = state_q;
      out_wr_d    = 1'b0;
      out_data_d  = out_data_q;
      out_ctrl_d  = out_ctrl_q;
      pkts_sent_d = pkts_sent_q;
      stop_pend_d = stop_pend_q;
      word_cnt_d  = word_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      pkt_idx_d   = pkt_idx_q;
      num_pkts_d  = num_pkts_q;
      plen_d      = plen_q;
      gap_d       = gap_q;
      dst_d       = dst_q;
      pattern_d   = pattern_q;
      pat_en_d    = pat_en_q;
      pat_off_d   = pat_off_q;

      if (state_q != IDLE && stop) stop_pend_d = 1'b1;

      case (state_q)
         IDLE: begin
            if (start) begin
               num_pkts_d  = num_pkts;
               plen_d      = (payload_len == 8'd0) ? 8'd1 : payload_len;
               gap_d       = gap_cycles;
               dst_d       = dst_port;
               pattern_d   = pattern;
               pat_en_d    = pat_en;
               pat_off_d   = pat_offset;
               pkt_idx_d   = 32'd0;
               word_cnt_d  = 8'd0;
               gap_cnt_d   = 8'd0;
               stop_pend_d = 1'b0;
               state_d     = MOD_HDR;
            end
         end
         MOD_HDR: begin
            if (out_rdy) begin
               out_wr_d   = 1'b1;
               out_data_d = DATA_WIDTH'({8'h00, dst_q, word_len, 16'h0000, byte_len});
               out_ctrl_d = CTRL_WIDTH'(CTRL_MOD_HDR);
               word_cnt_d = 8'd0;
               state_d    = HDR;
            end
         end
         HDR: begin
            if (out_rdy) begin
               out_wr_d   = 1'b1;
               out_data_d = DATA_WIDTH'(hdr_word(word_cnt_q[1:0]));
               out_ctrl_d = CTRL_WIDTH'(CTRL_BODY);
               if (word_cnt_q == LAST_HDR_IDX) begin
                  word_cnt_d = 8'd0;
                  state_d    = PAYLOAD;
               end else begin
                  word_cnt_d = word_cnt_q + 8'd1;
               end
            end
         end
         PAYLOAD: begin
            if (out_rdy) begin
               out_wr_d   = 1'b1;
               out_data_d = pat_hit ? DATA_WIDTH'(pattern_q)
                                    : DATA_WIDTH'({pkt_idx_q, 24'h000000, word_cnt_q});
               out_ctrl_d = last_pay ? CTRL_WIDTH'(CTRL_LAST) : CTRL_WIDTH'(CTRL_BODY);
               if (last_pay) begin
                  pkt_idx_d   = pkt_idx_inc;
                  pkts_sent_d = pkts_sent_q + 32'd1;
                  word_cnt_d  = 8'd0;
                  gap_cnt_d   = gap_q;
                  // A zero gap is a zero-length GAP: its exit decision is taken here.
                  if (gap_q != 8'd0)            state_d = GAP;
                  else if (quota_next || stop_req) state_d = IDLE;
                  else                          state_d = MOD_HDR;
               end else begin
                  word_cnt_d = word_cnt_q + 8'd1;
               end
            end
         end
         GAP: begin
            if (gap_cnt_q == 8'd1) begin
               gap_cnt_d = 8'd0;
               state_d   = (quota_now || stop_req) ? IDLE : MOD_HDR;
            end else begin
               gap_cnt_d = gap_cnt_q - 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (clear_cnt) pkts_sent_d = 32'd0;
      if (state_d == IDLE) stop_pend_d = 1'b0;
      busy_d = (state_d != IDLE);
   end

   // State, output and configuration registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         out_wr_q    <= 1'b0;
         out_data_q  <= '0;
         out_ctrl_q  <= '0;
         busy_q      <= 1'b0;
         pkts_sent_q <= 32'd0;
         stop_pend_q <= 1'b0;
         word_cnt_q  <= 8'd0;
         gap_cnt_q   <= 8'd0;
         pkt_idx_q   <= 32'd0;
         num_pkts_q  <= 32'd0;
         plen_q      <= 8'd0;
         gap_q       <= 8'd0;
         dst_q       <= 8'd0;
         pattern_q   <= 64'd0;
         pat_en_q    <= 1'b0;
         pat_off_q   <= 8'd0;
      end else begin
         state_q     <= state_d;
         out_wr_q    <= out_wr_d;
         out_data_q  <= out_data_d;
         out_ctrl_q  <= out_ctrl_d;
         busy_q      <= busy_d;
         pkts_sent_q <= pkts_sent_d;
         stop_pend_q <= stop_pend_d;
         word_cnt_q  <= word_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         pkt_idx_q   <= pkt_idx_d;
         num_pkts_q  <= num_pkts_d;
         plen_q      <= plen_d;
         gap_q       <= gap_d;
         dst_q       <= dst_d;
         pattern_q   <= pattern_d;
         pat_en_q    <= pat_en_d;
         pat_off_q   <= pat_off_d;
      end
   end

   assign out_wr    = out_wr_q;
   assign out_data  = out_data_q;
   assign out_ctrl  = out_ctrl_q;
   assign busy      = busy_q;
   assign pkts_sent = pkts_sent_q;

endmodule

// File: tb/tb_ids_pkt_gen.sv
// Self-checking bench for ids_pkt_gen: vector table, corner-case sequences
// and randomized runs checked against a packet-list reference model.
module tb_ids_pkt_gen;
   import ids_pkt_pkg::*;

   logic        clk;
   logic        reset;
   logic [63:0] out_data;
   logic [7:0]  out_ctrl;
   logic        out_wr;
   logic        out_rdy;
   logic        start;
   logic        stop;
   logic [31:0] num_pkts;
   logic [7:0]  payload_len;
   logic [7:0]  gap_cycles;
   logic [7:0]  dst_port;
   logic [63:0] pattern;
   logic        pat_en;
   logic [7:0]  pat_offset;
   logic        clear_cnt;
   logic        busy;
   logic [31:0] pkts_sent;

   ids_pkt_gen dut (
      .clk(clk), .reset(reset), .out_data(out_data), .out_ctrl(out_ctrl),
      .out_wr(out_wr), .out_rdy(out_rdy), .start(start), .stop(stop),
      .num_pkts(num_pkts), .payload_len(payload_len), .gap_cycles(gap_cycles),
      .dst_port(dst_port), .pattern(pattern), .pat_en(pat_en),
      .pat_offset(pat_offset), .clear_cnt(clear_cnt), .busy(busy),
      .pkts_sent(pkts_sent)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] num_pkts;
      logic [7:0]  plen;
      logic [7:0]  gap;
      logic [7:0]  dst;
      logic        pat_en;
      logic [7:0]  pat_off;
      logic [63:0] pattern;
   } cfg_t;

   typedef struct {
      cfg_t        cfg;
      int          exp_words;
      logic [15:0] exp_wlen;
      logic [15:0] exp_blen;
      logic [63:0] exp_last;
   } vec_t;

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   int rdy_mode = 0;   // 0 hold, 1 toggle every cycle, 2 random

   logic [63:0] got_d[$];
   logic [7:0]  got_c[$];
   int          got_t[$];
   logic [63:0] exp_d[$];
   logic [7:0]  exp_c[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One clock: capture any written word, check it followed out_rdy=1, then drive out_rdy.
   task automatic tick();
      @(negedge clk);
      cyc++;
      if (out_wr === 1'b1) begin
         got_d.push_back(out_data);
         got_c.push_back(out_ctrl);
         got_t.push_back(cyc);
         chk("wr_after_rdy", 64'(out_rdy), 64'd1);
      end
      if (rdy_mode == 1)      out_rdy = ~out_rdy;
      else if (rdy_mode == 2) out_rdy = 1'($urandom_range(0, 1));
   endtask

   function automatic cfg_t mk(input logic [31:0] n, input logic [7:0] pl, input logic [7:0] g,
                               input logic [7:0] d, input logic pe, input logic [7:0] po,
                               input logic [63:0] pat);
      cfg_t c;
      c.num_pkts = n; c.plen = pl; c.gap = g; c.dst = d;
      c.pat_en = pe; c.pat_off = po; c.pattern = pat;
      return c;
   endfunction

   // Reference: the full list of words a run of npk packets must produce.
   task automatic build_exp(input cfg_t c, input int npk);
      int pl;
      logic [15:0] wl, bl;
      pl = (c.plen == 8'd0) ? 1 : int'(c.plen);
      wl = 16'(pl + 3);
      bl = 16'((pl + 3) * 8);
      exp_d.delete();
      exp_c.delete();
      for (int p = 0; p < npk; p++) begin
         exp_d.push_back({8'h00, c.dst, wl, 16'h0000, bl}); exp_c.push_back(8'hFF);
         exp_d.push_back(HDR_W1); exp_c.push_back(8'h00);
         exp_d.push_back(HDR_W2); exp_c.push_back(8'h00);
         exp_d.push_back(HDR_W3); exp_c.push_back(8'h00);
         for (int k = 0; k < pl; k++) begin
            if (c.pat_en && k == int'(c.pat_off)) exp_d.push_back(c.pattern);
            else exp_d.push_back({32'(p), 24'h000000, 8'(k)});
            exp_c.push_back((k == pl - 1) ? 8'h01 : 8'h00);
         end
      end
   endtask

   task automatic clear_got();
      got_d.delete(); got_c.delete(); got_t.delete();
   endtask

   task automatic compare_run(input string name);
      int n, bad;
      bad = 0;
      chk({name, "_count"}, 64'(got_d.size()), 64'(exp_d.size()));
      n = (got_d.size() < exp_d.size()) ? got_d.size() : exp_d.size();
      for (int i = 0; i < n; i++) begin
         n_cmp++;
         if (got_d[i] !== exp_d[i] || got_c[i] !== exp_c[i]) begin
            n_fail++;
            if (bad < 4)
               $display("FAIL %s word %0d: got %h/%h expected %h/%h",
                        name, i, got_d[i], got_c[i], exp_d[i], exp_c[i]);
            bad++;
         end
      end
   endtask

   task automatic check_gaps(input string name, input int wpp, input int gap);
      for (int p = 1; p * wpp < got_t.size(); p++)
         chk({name, "_idle"}, 64'(got_t[p*wpp] - got_t[p*wpp-1] - 1), 64'(gap));
   endtask

   task automatic pulse_clear();
      clear_cnt = 1'b1; tick(); clear_cnt = 1'b0;
      chk("clear_cnt", 64'(pkts_sent), 64'd0);
   endtask

   // Start a run, then scramble the config inputs to prove they were latched.
   task automatic launch(input cfg_t c);
      num_pkts = c.num_pkts; payload_len = c.plen; gap_cycles = c.gap; dst_port = c.dst;
      pat_en = c.pat_en; pat_offset = c.pat_off; pattern = c.pattern;
      start = 1'b1; tick(); start = 1'b0;
      chk("busy_rise", 64'(busy), 64'd1);
      num_pkts = $urandom; payload_len = 8'($urandom); gap_cycles = 8'($urandom);
      dst_port = 8'($urandom); pat_en = 1'($urandom); pat_offset = 8'($urandom);
      pattern = {$urandom, $urandom};
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (busy === 1'b1 && n < 3000) begin tick(); n++; end
      chk({name, "_done"}, 64'(busy), 64'd0);
   endtask

   task automatic run_and_check(input cfg_t c, input int npk, input string name, input bit gaps);
      pulse_clear();
      clear_got();
      launch(c);
      if (busy === 1'b1) begin start = 1'b1; tick(); start = 1'b0; end
      wait_idle(name);
      repeat (3) tick();
      build_exp(c, npk);
      compare_run(name);
      chk({name, "_sent"}, 64'(pkts_sent), 64'(npk));
      if (gaps) check_gaps(name, (c.plen == 8'd0 ? 1 : int'(c.plen)) + 4, int'(c.gap));
   endtask

   vec_t vecs[6];

   initial begin
      cfg_t c;
      int n, clr_cyc;

      vecs[0] = '{cfg: mk(1, 4, 0, 8'h01, 0, 0, 64'h0), exp_words: 8,
                  exp_wlen: 16'd7, exp_blen: 16'd56, exp_last: 64'h3};
      vecs[1] = '{cfg: mk(1, 4, 0, 8'h02, 1, 3, 64'h0102030405060708), exp_words: 8,
                  exp_wlen: 16'd7, exp_blen: 16'd56, exp_last: 64'h0102030405060708};
      vecs[2] = '{cfg: mk(1, 0, 2, 8'h04, 0, 0, 64'h0), exp_words: 5,
                  exp_wlen: 16'd4, exp_blen: 16'd32, exp_last: 64'h0};
      vecs[3] = '{cfg: mk(2, 2, 3, 8'h08, 1, 5, 64'hDEAD_BEEF_0000_0001), exp_words: 12,
                  exp_wlen: 16'd5, exp_blen: 16'd40, exp_last: 64'h0000_0001_0000_0001};
      vecs[4] = '{cfg: mk(3, 1, 0, 8'h10, 1, 0, 64'hCAFE_F00D_1234_5678), exp_words: 15,
                  exp_wlen: 16'd4, exp_blen: 16'd32, exp_last: 64'hCAFE_F00D_1234_5678};
      vecs[5] = '{cfg: mk(1, 255, 1, 8'h80, 0, 0, 64'h0), exp_words: 259,
                  exp_wlen: 16'd258, exp_blen: 16'd2064, exp_last: 64'hFE};

      reset = 1'b1; out_rdy = 1'b1; start = 1'b0; stop = 1'b0; clear_cnt = 1'b0;
      num_pkts = 32'd0; payload_len = 8'd0; gap_cycles = 8'd0; dst_port = 8'd0;
      pattern = 64'd0; pat_en = 1'b0; pat_offset = 8'd0;
      repeat (3) tick();
      chk("rst_out_wr", 64'(out_wr), 64'd0);
      chk("rst_out_data", out_data, 64'd0);
      chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_pkts_sent", 64'(pkts_sent), 64'd0);
      reset = 1'b0;
      tick();

      // Table-driven vectors, ready held high.
      foreach (vecs[i]) begin
         run_and_check(vecs[i].cfg, int'(vecs[i].cfg.num_pkts), $sformatf("vec%0d", i), 1'b1);
         chk($sformatf("vec%0d_words", i), 64'(got_d.size()), 64'(vecs[i].exp_words));
         if (got_d.size() > 0) begin
            chk($sformatf("vec%0d_wlen", i), 64'(got_d[0][47:32]), 64'(vecs[i].exp_wlen));
            chk($sformatf("vec%0d_blen", i), 64'(got_d[0][15:0]), 64'(vecs[i].exp_blen));
            chk($sformatf("vec%0d_last", i), got_d[got_d.size()-1], vecs[i].exp_last);
            chk($sformatf("vec%0d_lastctl", i), 64'(got_c[got_c.size()-1]), 64'h01);
         end else begin
            chk($sformatf("vec%0d_nowords", i), 64'd0, 64'd1);
         end
      end

      // Ready toggling mid-packet.
      rdy_mode = 1;
      run_and_check(mk(1, 6, 0, 8'h20, 0, 0, 64'h0), 1, "toggle", 1'b0);
      rdy_mode = 0; out_rdy = 1'b1;

      // Stop while idle must not shorten the next run.
      stop = 1'b1; tick(); stop = 1'b0;
      run_and_check(mk(2, 2, 0, 8'h40, 0, 0, 64'h0), 2, "stop_idle", 1'b1);

      // Continuous run, stop during the third packet.
      c = mk(0, 3, 5, 8'h04, 0, 0, 64'h0);
      pulse_clear();
      clear_got();
      launch(c);
      n = 0;
      while (pkts_sent != 32'd2 && n < 500) begin tick(); n++; end
      chk("cont_two_sent", 64'(pkts_sent), 64'd2);
      n = 0;
      while (got_d.size() < 16 && n < 500) begin tick(); n++; end
      stop = 1'b1; tick(); stop = 1'b0;
      chk("cont_busy_after_stop", 64'(busy), 64'd1);
      wait_idle("cont");
      repeat (3) tick();
      build_exp(c, 3);
      compare_run("cont");
      chk("cont_sent", 64'(pkts_sent), 64'd3);
      check_gaps("cont", 7, 5);

      // Reset while emitting header words.
      clear_got();
      launch(mk(1, 4, 0, 8'h01, 0, 0, 64'h0));
      tick();
      reset = 1'b1; tick();
      chk("midrst_out_wr", 64'(out_wr), 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_sent", 64'(pkts_sent), 64'd0);
      reset = 1'b0;
      n = got_d.size();
      repeat (5) tick();
      chk("midrst_quiet", 64'(got_d.size()), 64'(n));
      run_and_check(mk(1, 4, 0, 8'h01, 0, 0, 64'h0), 1, "after_rst", 1'b1);

      // clear_cnt in the same cycle as the last-word completion.
      chk("pre_clr_nonzero", 64'(pkts_sent != 32'd0), 64'd1);
      clear_got();
      launch(mk(1, 2, 0, 8'h10, 0, 0, 64'h0));
      repeat (5) tick();
      clear_cnt = 1'b1; clr_cyc = cyc; tick(); clear_cnt = 1'b0;
      wait_idle("clr_race");
      if (got_t.size() > 0) chk("clr_align", 64'(got_t[got_t.size()-1]), 64'(clr_cyc + 1));
      else chk("clr_nowords", 64'd0, 64'd1);
      chk("clr_race_sent", 64'(pkts_sent), 64'd0);

      // Randomized runs.
      for (int r = 0; r < 10; r++) begin
         c = mk(32'($urandom_range(1, 3)), 8'($urandom_range(0, 10)), 8'($urandom_range(0, 4)),
                8'(1 << $urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                8'($urandom_range(0, 12)), {$urandom, $urandom});
         rdy_mode = (r % 2 == 0) ? 2 : 0;
         out_rdy = 1'b1;
         run_and_check(c, int'(c.num_pkts), $sformatf("rand%0d", r), rdy_mode == 0);
      end
      rdy_mode = 0; out_rdy = 1'b1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/ids_pkt_gen.md
IDS_PKT_GEN -- requirements
Module: ids_pkt_gen

Interface
REQ-001 Parameter DATA_WIDTH, default 64, datapath width; the block SHALL support only 64.
REQ-002 Parameter CTRL_WIDTH, default DATA_WIDTH/8, ctrl width.
REQ-003 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 out_data  output  DATA_WIDTH  packet word to the next data-path module.
REQ-006 out_ctrl  output  CTRL_WIDTH  word ctrl: 8'hFF module header, 8'h00 body, 8'h01 last word (all 8 bytes valid).
REQ-007 out_wr  output  1  word valid strobe.
REQ-008 out_rdy  input  1  downstream not-nearly-full.
REQ-009 start  input  1  one-cycle pulse; begins a run.
REQ-010 stop  input  1  one-cycle pulse; ends the run at the next packet boundary.
REQ-011 num_pkts  input  32  packets per run; 0 means continuous until stop.
REQ-012 payload_len  input  8  payload words per packet; 0 treated as 1.
REQ-013 gap_cycles  input  8  idle cycles after each last word.
REQ-014 dst_port  input  8  one-hot output port placed in the module header.
REQ-015 pattern  input  64  word inserted into the payload.
REQ-016 pat_en  input  1  enables pattern insertion.
REQ-017 pat_offset  input  8  payload word index of the pattern.
REQ-018 clear_cnt  input  1  zeroes pkts_sent.
REQ-019 busy  output  1  high from the cycle after an accepted start until the run ends.
REQ-020 pkts_sent  output  32  count of completed packets; wraps modulo 2^32.

Function
REQ-021 FSM states SHALL be IDLE, MOD_HDR, HDR, PAYLOAD, GAP.
REQ-022 In IDLE, start SHALL latch all configuration inputs and go to MOD_HDR; start while busy SHALL be ignored.
REQ-023 Outputs SHALL be registered: a word appears with out_wr=1 in cycle t+1 only if out_rdy=1 in cycle t; otherwise out_wr=0 and the FSM SHALL hold.
REQ-024 MOD_HDR SHALL emit one word, ctrl 8'hFF, data {8'h00,dst_port,word_len[15:0],16'h0000,byte_len[15:0]}.
REQ-025 In REQ-024, word_len = 3 + payload_len and byte_len = 8*word_len.
REQ-026 HDR SHALL emit exactly 3 words, ctrl 8'h00, with data HDR_W1..HDR_W3 from the package.
REQ-027 PAYLOAD word k (0..payload_len-1) data SHALL be pattern if pat_en and k==pat_offset, else {pkt_idx[31:0],16'h0000,8'h00,k[7:0]}.
REQ-028 pkt_idx in REQ-027 is the zero-based packet index within the run.
REQ-029 Payload ctrl SHALL be 8'h00 except for word payload_len-1, which SHALL be 8'h01, including when that word carries the pattern.
REQ-030 pat_offset >= payload_len SHALL result in no insertion; packet length SHALL be unchanged.
REQ-031 After the last word is written, pkts_sent SHALL increment and the FSM SHALL go to GAP.
REQ-032 The FSM SHALL hold GAP for gap_cycles cycles, with 0 meaning none.
REQ-033 From GAP the FSM SHALL go to IDLE if the packet quota is met or stop is pending; otherwise to MOD_HDR.
REQ-034 stop SHALL be latched as pending; a packet in progress SHALL never be truncated.
REQ-035 stop in IDLE SHALL have no effect.
REQ-036 busy SHALL fall in the cycle the FSM enters IDLE.
REQ-037 If clear_cnt and a completion occur in the same cycle, clear SHALL win and pkts_sent SHALL be 0.
REQ-038 out_wr SHALL never be high in IDLE or GAP.

Reset
REQ-039 Reset SHALL force IDLE, out_wr=0, out_data=0, out_ctrl=0, busy=0, pkts_sent=0, pending stop=0, and all counters to 0.
REQ-040 Reset mid-packet SHALL abort the packet immediately, with no further words written.

Structure
REQ-041 Package ids_pkt_pkg SHALL hold the FSM state encodings, CTRL_MOD_HDR/CTRL_BODY/CTRL_LAST, HDR_W1..HDR_W3 and NUM_HDR_WORDS=3.
REQ-042 The block SHALL be a single module with no sub-module; the word-data mux SHALL be inline.

Verification
REQ-043 Scenario: num_pkts=1, payload_len=4, pat_en=0, out_rdy=1 -> 8 words; ctrl FF,00,00,00,00,00,00,01; word_len=7, byte_len=56; pkts_sent=1; busy low afterwards.
REQ-044 Scenario: pat_en=1, pat_offset=3, payload_len=4, pattern=64'h0102030405060708 -> last word data = pattern with ctrl 01.
REQ-045 Scenario: out_rdy toggled 1,0,1,0 mid-packet -> no word lost or duplicated, and out_wr never follows an out_rdy=0 cycle.
REQ-046 Scenario: num_pkts=0, gap_cycles=5, stop pulsed during packet 2 -> packet 2 completes intact, pkts_sent=3, and exactly 5 idle cycles occur between packets.
REQ-047 Scenario: reset asserted during HDR -> next cycle out_wr=0 and state IDLE; a following start -> a clean new packet with pkt_idx=0.
REQ-048 Scenario: clear_cnt coincident with a last-word completion -> pkts_sent=0.
